// File: rtl/sr_drv_pkg.sv
// Shared types for the MSff driver: command codes, FSM states,
// response error bit positions and the command decoder.
package sr_drv_pkg;

    typedef enum logic [1:0] {
        CMD_HOLD   = 2'd0,
        CMD_SET    = 2'd1,
        CMD_RESET  = 2'd2,
        CMD_TOGGLE = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_MASTER,
        ST_SLAVE,
        ST_RESP
    } state_e;

    localparam int ERR_M_CMP  = 0;
    localparam int ERR_M_CPL  = 1;
    localparam int ERR_S_CMP  = 2;
    localparam int ERR_S_CPL  = 3;

    typedef struct packed {
        logic r;
        logic s;
        logic tgt;
        logic known;
    } drive_t;

    // Map a command onto R/S drive levels and the state it should produce.
    // A TOGGLE with no known state degrades to HOLD with an unknown target.
    function automatic drive_t decode_cmd(
        input cmd_e c,
        input logic exp_q,
        input logic exp_known
    );
        drive_t d;
        d.r     = 1'b0;
        d.s     = 1'b0;
        d.tgt   = exp_q;
        d.known = exp_known;
        unique case (c)
            CMD_SET: begin
                d.s     = 1'b1;
                d.tgt   = 1'b1;
                d.known = 1'b1;
            end
            CMD_RESET: begin
                d.r     = 1'b1;
                d.tgt   = 1'b0;
                d.known = 1'b1;
            end
            CMD_TOGGLE: begin
                if (exp_known) begin
                    d.r   = exp_q;
                    d.s   = ~exp_q;
                    d.tgt = ~exp_q;
                end
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sr_ff_driver_phase_timer.sv
// Loadable down-counter timing each phase of the FF clock.
// done is high while the count sits at zero.
module phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load takes priority; otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/sr_ff_driver.sv
// Drives CLK/R/S of a master-slave SR flip-flop from a command stream
// and checks the sampled master and slave outputs against the target.
module sr_ff_driver
    import sr_drv_pkg::*;
#(
    parameter int HALF_CYCLES = 4,
    parameter int SETTLE      = 2,
    parameter int ERR_W       = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    output logic             cmd_ready,
    output logic             ff_clk,
    output logic             ff_r,
    output logic             ff_s,
    input  logic             ff_q,
    input  logic             ff_q_l,
    input  logic             ff_p,
    input  logic             ff_p_l,
    output logic             rsp_valid,
    output logic             rsp_q,
    output logic [3:0]       rsp_err,
    output logic             exp_q,
    output logic             exp_known,
    output logic [ERR_W-1:0] err_count
);

    localparam int MAXPH = (HALF_CYCLES > SETTLE) ? HALF_CYCLES : SETTLE;
    localparam int TW    = $clog2(MAXPH + 1);

    localparam logic [TW-1:0]    SETTLE_LD = TW'(SETTLE - 1);
    localparam logic [TW-1:0]    HALF_LD   = TW'(HALF_CYCLES - 1);
    localparam logic [ERR_W-1:0] CNT_ONE   = ERR_W'(1);

    state_e state_q, state_d;

    logic             ff_clk_q, ff_clk_d;
    logic             ff_r_q, ff_r_d;
    logic             ff_s_q, ff_s_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_q_q, rsp_q_d;
    logic [3:0]       rsp_err_q, rsp_err_d;
    logic             exp_q_q, exp_q_d;
    logic             exp_known_q, exp_known_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             tgt_q, tgt_d;
    logic             tgt_known_q, tgt_known_d;
    logic [1:0]       mchk_q, mchk_d;
    logic [3:0]       in_q, in_d;

    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_done;
    drive_t           dec;

    logic             q_s, q_l_s, p_s, p_l_s;

    phase_timer #(
        .W(TW)
    ) u_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign q_s   = in_q[0];
    assign q_l_s = in_q[1];
    assign p_s   = in_q[2];
    assign p_l_s = in_q[3];

    // One register stage on every FF output before any compare.
    always_comb begin
        in_d = {ff_p_l, ff_p, ff_q_l, ff_q};
    end

    // Next state, FF drive levels, checks and response bookkeeping.
    always_comb begin
        state_d     = state_q;
        tmr_load    = 1'b0;
        tmr_val     = SETTLE_LD;
        ff_r_d      = ff_r_q;
        ff_s_d      = ff_s_q;
        tgt_d       = tgt_q;
        tgt_known_d = tgt_known_q;
        mchk_d      = mchk_q;
        rsp_valid_d = 1'b0;
        rsp_q_d     = rsp_q_q;
        rsp_err_d   = rsp_err_q;
        exp_q_d     = exp_q_q;
        exp_known_d = exp_known_q;
        err_count_d = err_count_q;
        dec         = decode_cmd(cmd_e'(cmd), exp_q_q, exp_known_q);

        unique case (state_q)
            ST_IDLE: begin
                ff_r_d = 1'b0;
                ff_s_d = 1'b0;
                if (cmd_valid) begin
                    state_d     = ST_SETUP;
                    tmr_load    = 1'b1;
                    tmr_val     = SETTLE_LD;
                    ff_r_d      = dec.r;
                    ff_s_d      = dec.s;
                    tgt_d       = dec.tgt;
                    tgt_known_d = dec.known;
                    mchk_d      = 2'b00;
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    state_d  = ST_MASTER;
                    tmr_load = 1'b1;
                    tmr_val  = HALF_LD;
                end
            end
            ST_MASTER: begin
                if (tmr_done) begin
                    state_d   = ST_SLAVE;
                    tmr_load  = 1'b1;
                    tmr_val   = HALF_LD;
                    mchk_d[0] = tgt_known_q & (p_s != tgt_q);
                    mchk_d[1] = (p_l_s == p_s);
                end
            end
            ST_SLAVE: begin
                ff_r_d = 1'b0;
                ff_s_d = 1'b0;
                if (tmr_done) begin
                    state_d              = ST_RESP;
                    rsp_valid_d          = 1'b1;
                    rsp_q_d              = q_s;
                    rsp_err_d[ERR_M_CMP] = mchk_q[0];
                    rsp_err_d[ERR_M_CPL] = mchk_q[1];
                    rsp_err_d[ERR_S_CMP] = tgt_known_q & (q_s != tgt_q);
                    rsp_err_d[ERR_S_CPL] = (q_l_s == q_s);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (tgt_known_q) begin
                    exp_q_d = tgt_q;
                end
                exp_known_d = exp_known_q | tgt_known_q;
                if ((rsp_err_q != 4'b0000) && (err_count_q != '1)) begin
                    err_count_d = err_count_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ff_r_d  = 1'b0;
                ff_s_d  = 1'b0;
            end
        endcase

        ff_clk_d    = (state_d == ST_MASTER);
        cmd_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset drops the FF drive at once.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            ff_clk_q    <= 1'b0;
            ff_r_q      <= 1'b0;
            ff_s_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_q_q     <= 1'b0;
            rsp_err_q   <= 4'b0000;
            exp_q_q     <= 1'b0;
            exp_known_q <= 1'b0;
            err_count_q <= '0;
            tgt_q       <= 1'b0;
            tgt_known_q <= 1'b0;
            mchk_q      <= 2'b00;
            in_q        <= 4'b0000;
        end else begin
            state_q     <= state_d;
            ff_clk_q    <= ff_clk_d;
            ff_r_q      <= ff_r_d;
            ff_s_q      <= ff_s_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q_q     <= rsp_q_d;
            rsp_err_q   <= rsp_err_d;
            exp_q_q     <= exp_q_d;
            exp_known_q <= exp_known_d;
            err_count_q <= err_count_d;
            tgt_q       <= tgt_d;
            tgt_known_q <= tgt_known_d;
            mchk_q      <= mchk_d;
            in_q        <= in_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign ff_clk    = ff_clk_q;
    assign ff_r      = ff_r_q;
    assign ff_s      = ff_s_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_q     = rsp_q_q;
    assign rsp_err   = rsp_err_q;
    assign exp_q     = exp_q_q;
    assign exp_known = exp_known_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_sr_ff_driver.sv
// Bench for sr_ff_driver: behavioural MSff with fault hooks, directed
// table, reset/busy sequences and a randomized scoreboard.
module tb_sr_ff_driver;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'd0;
    logic       cmd_ready, ff_clk, ff_r, ff_s;
    logic       ff_q, ff_q_l, ff_p, ff_p_l;
    logic       rsp_valid, rsp_q, exp_q, exp_known;
    logic [3:0] rsp_err;
    logic [7:0] err_count;

    sr_ff_driver dut (
        .CLK       (CLK),
        .RST       (RST),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .ff_clk    (ff_clk),
        .ff_r      (ff_r),
        .ff_s      (ff_s),
        .ff_q      (ff_q),
        .ff_q_l    (ff_q_l),
        .ff_p      (ff_p),
        .ff_p_l    (ff_p_l),
        .rsp_valid (rsp_valid),
        .rsp_q     (rsp_q),
        .rsp_err   (rsp_err),
        .exp_q     (exp_q),
        .exp_known (exp_known),
        .err_count (err_count)
    );

    always #5 CLK = ~CLK;

    // Behavioural MSff: master follows S/R while CLK high, slave copies
    // master while CLK low. Powers up holding 1.
    logic m_st = 1'b1;
    logic s_st = 1'b1;
    logic f_q0 = 1'b0;
    logic f_qleq = 1'b0;

    always @(posedge CLK) begin
        if (ff_clk) begin
            if (ff_s) m_st <= 1'b1;
            else if (ff_r) m_st <= 1'b0;
        end else begin
            s_st <= m_st;
        end
    end

    assign ff_p   = m_st;
    assign ff_p_l = ~m_st;
    assign ff_q   = f_q0 ? 1'b0 : s_st;
    assign ff_q_l = f_qleq ? ff_q : ~ff_q;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Scoreboard: expected response computed at acceptance.
    typedef struct {
        logic       q;
        logic [3:0] err;
        logic       eq;
        logic       ek;
        int         cnt;
        int         acc;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    logic mk = 1'b0;
    logic me = 1'b0;
    int   mc = 0;
    int   cyc = 0;
    bit   post = 1'b0;

    always @(negedge CLK) begin
        exp_t e;
        logic kt, tg;
        cyc++;
        n_chk++;
        if (ff_r === 1'b1 && ff_s === 1'b1) begin
            n_fail++;
            $display("FAIL rs_invariant: r=%b s=%b at cycle %0d", ff_r, ff_s, cyc);
        end
        if (RST) begin
            sb.delete();
            mk = 1'b0;
            me = 1'b0;
            mc = 0;
            post = 1'b0;
        end else begin
            if (post) begin
                chk("sb_exp_q", exp_q, last.eq);
                chk("sb_exp_known", exp_known, last.ek);
                chk("sb_err_count", err_count, last.cnt);
                post = 1'b0;
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_rsp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_rsp_q", rsp_q, e.q);
                    chk("sb_rsp_err", rsp_err, e.err);
                    chk("sb_latency", cyc - e.acc, 11);
                    last = e;
                    post = 1'b1;
                end
            end
            if (cmd_valid && cmd_ready) begin
                kt = mk;
                tg = me;
                case (cmd)
                    2'd1: begin kt = 1'b1; tg = 1'b1; end
                    2'd2: begin kt = 1'b1; tg = 1'b0; end
                    2'd3: tg = ~me;
                    default: ;
                endcase
                e.q   = f_q0 ? 1'b0 : (kt ? tg : s_st);
                e.err = {f_qleq, f_q0 & kt & tg, 2'b00};
                if (kt) me = tg;
                if (cmd == 2'd1 || cmd == 2'd2) mk = 1'b1;
                if (e.err != 4'b0 && mc < 255) mc++;
                e.eq  = me;
                e.ek  = mk;
                e.cnt = mc;
                e.acc = cyc;
                sb.push_back(e);
            end
        end
    end

    task automatic issue(input logic [1:0] c, input logic fq0,
                         input logic fqleq, output logic q,
                         output logic [3:0] err, output int lat);
        q = 1'b0;
        err = 4'h0;
        lat = -1;
        @(posedge CLK);
        #1;
        f_q0 = fq0;
        f_qleq = fqleq;
        cmd = c;
        cmd_valid = 1'b1;
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (rsp_valid) begin
                lat = i;
                q = rsp_q;
                err = rsp_err;
                break;
            end
        end
        @(negedge CLK);
        f_q0 = 1'b0;
        f_qleq = 1'b0;
    endtask

    typedef struct {
        logic [1:0] c;
        logic       fq0;
        logic       fqleq;
        logic       q;
        logic [3:0] err;
        logic       eq;
        logic       ek;
        int         cnt;
    } vec_t;

    vec_t tv[9];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        logic       q;
        logic [3:0] err;
        int         lat;
        bit         seen;

        tv[0] = '{2'd0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 0};
        tv[1] = '{2'd1, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 0};
        tv[2] = '{2'd0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 0};
        tv[3] = '{2'd2, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 0};
        tv[4] = '{2'd3, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 0};
        tv[5] = '{2'd3, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 0};
        tv[6] = '{2'd1, 1'b1, 1'b0, 1'b0, 4'h4, 1'b1, 1'b1, 1};
        tv[7] = '{2'd0, 1'b0, 1'b1, 1'b1, 4'h8, 1'b1, 1'b1, 2};
        tv[8] = '{2'd3, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 2};

        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_drive", {ff_clk, ff_r, ff_s}, 0);
        chk("rst_rsp", {rsp_valid, rsp_q, rsp_err}, 0);
        chk("rst_exp", {exp_q, exp_known}, 0);
        chk("rst_err_count", err_count, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        for (int i = 0; i < 9; i++) begin
            issue(tv[i].c, tv[i].fq0, tv[i].fqleq, q, err, lat);
            chk($sformatf("tv%0d_latency", i), lat, 11);
            chk($sformatf("tv%0d_rsp_q", i), q, tv[i].q);
            chk($sformatf("tv%0d_rsp_err", i), err, tv[i].err);
            chk($sformatf("tv%0d_exp_q", i), exp_q, tv[i].eq);
            chk($sformatf("tv%0d_exp_known", i), exp_known, tv[i].ek);
            chk($sformatf("tv%0d_err_count", i), err_count, tv[i].cnt);
        end

        for (int i = 0; i < 300; i++) begin
            issue(2'd0, 1'b0, 1'b1, q, err, lat);
        end
        chk("sat_err_count", err_count, 255);
        chk("sat_last_err", err, 4'h8);

        // Busy: valid held high, command changing every cycle.
        @(posedge CLK);
        #1;
        cmd_valid = 1'b1;
        repeat (60) begin
            cmd = 2'($urandom);
            @(posedge CLK);
            #1;
        end
        cmd_valid = 1'b0;
        repeat (20) @(posedge CLK);
        @(negedge CLK);
        chk("busy_drained", sb.size(), 0);

        // Reset while in the master phase of a SET.
        @(posedge CLK);
        #1;
        cmd = 2'd1;
        cmd_valid = 1'b1;
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("mid_in_master", ff_clk, 1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("abort_drive", {ff_clk, ff_r, ff_s}, 0);
        chk("abort_ready", cmd_ready, 1);
        chk("abort_known", exp_known, 0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            if (rsp_valid) seen = 1'b1;
        end
        chk("abort_no_rsp", seen, 0);
        issue(2'd1, 1'b0, 1'b0, q, err, lat);
        chk("post_abort_latency", lat, 11);
        chk("post_abort_q", q, 1);
        chk("post_abort_err", err, 0);
        chk("post_abort_exp", {exp_q, exp_known}, 2'b11);

        // Random commands, faults and junk requests while busy.
        for (int n = 0; n < 150; n++) begin
            @(posedge CLK);
            #1;
            f_q0 = ($urandom_range(0, 3) == 0);
            f_qleq = ($urandom_range(0, 3) == 0);
            cmd = 2'($urandom);
            cmd_valid = 1'b1;
            @(posedge CLK);
            #1;
            repeat (10) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd = 2'($urandom);
                @(posedge CLK);
                #1;
            end
            cmd_valid = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge CLK);
                if (cmd_ready) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) chk("rand_ready_timeout", 0, 1);
            repeat ($urandom_range(0, 2)) @(posedge CLK);
        end
        f_q0 = 1'b0;
        f_qleq = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rand_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
